// File: rtl/snake_position_if.sv
// Bundle between the snake position unit and its driver.
// Inputs are control strobes; outputs carry the packed body.
interface snake_position_if;
  logic         refresh_tick;
  logic         dir_valid;
  logic [1:0]   dir_in;
  logic         grow;
  logic         halt;
  logic [659:0] position;
  logic [5:0]   length;
  logic         move_tick;

  modport master (
    output refresh_tick, dir_valid, dir_in, grow, halt,
    input  position, length, move_tick
  );

  modport slave (
    input  refresh_tick, dir_valid, dir_in, grow, halt,
    output position, length, move_tick
  );
endinterface

// File: rtl/snake_position.sv
// Snake head/body coordinate store: steps, wraps and grows
// the snake once every MOVE_DIV refresh ticks.
module snake_position #(
  parameter int STEP     = 10,
  parameter int H_MAX    = 640,
  parameter int V_MAX    = 480,
  parameter int MOVE_DIV = 4,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int INIT_LEN = 3
) (
  input logic             clk,
  input logic             reset,
  snake_position_if.slave bus
);
  localparam int N  = 33;
  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);
  localparam logic [1:0] UP = 2'd0;
  localparam logic [1:0] DN = 2'd1;
  localparam logic [1:0] LF = 2'd2;
  localparam logic [1:0] RT = 2'd3;

  logic [9:0]    r_x [N];
  logic [9:0]    r_y [N];
  logic [5:0]    r_len;
  logic [1:0]    r_cur;
  logic [1:0]    r_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_gp;
  logic          r_moved;
  logic          r_mt;

  logic          w_move;
  logic          w_grow;
  logic          w_rev;
  logic [10:0]   w_sx;
  logic [10:0]   w_sy;
  logic [9:0]    w_hx;
  logic [9:0]    w_hy;
  logic [659:0]  w_pos;

  assign w_move = bus.refresh_tick & ~bus.halt & (r_cnt == LAST);
  assign w_grow = (r_gp | bus.grow) & (r_len < 6'd33);
  // opposite directions share bit 1 and differ in bit 0
  assign w_rev  = (bus.dir_in[1] == r_cur[1]) &
                  (bus.dir_in[0] != r_cur[0]);

  always_comb begin
    w_sx = {1'b0, r_x[0]} + 11'(STEP);
    w_sy = {1'b0, r_y[0]} + 11'(STEP);
    w_hx = r_x[0];
    w_hy = r_y[0];
    unique case (r_nxt)
      UP: w_hy = (r_y[0] == 10'd0) ? 10'(V_MAX - STEP)
                                   : r_y[0] - 10'(STEP);
      DN: w_hy = (w_sy >= 11'(V_MAX)) ? 10'd0 : w_sy[9:0];
      LF: w_hx = (r_x[0] == 10'd0) ? 10'(H_MAX - STEP)
                                   : r_x[0] - 10'(STEP);
      RT: w_hx = (w_sx >= 11'(H_MAX)) ? 10'd0 : w_sx[9:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_x[k] <= (k < INIT_LEN) ? 10'(INIT_X - k * STEP) : 10'd0;
        r_y[k] <= (k < INIT_LEN) ? 10'(INIT_Y) : 10'd0;
      end
      r_len   <= 6'(INIT_LEN);
      r_cur   <= RT;
      r_nxt   <= RT;
      r_cnt   <= '0;
      r_gp    <= 1'b0;
      r_moved <= 1'b0;
      r_mt    <= 1'b0;
    end else begin
      r_moved <= w_move;
      r_mt    <= r_moved;
      if (bus.dir_valid && !w_rev)
        r_nxt <= bus.dir_in;
      if (bus.refresh_tick && !bus.halt)
        r_cnt <= w_move ? '0 : r_cnt + CW'(1);
      if (w_move) begin
        r_cur  <= r_nxt;
        r_gp   <= 1'b0;
        r_x[0] <= w_hx;
        r_y[0] <= w_hy;
        // the slot just past the old tail is dropped unless growing
        for (int k = 1; k < N; k++) begin
          if (6'(k) == r_len && !w_grow) begin
            r_x[k] <= 10'd0;
            r_y[k] <= 10'd0;
          end else begin
            r_x[k] <= r_x[k-1];
            r_y[k] <= r_y[k-1];
          end
        end
        if (w_grow)
          r_len <= r_len + 6'd1;
      end else if (bus.grow) begin
        r_gp <= 1'b1;
      end
    end
  end

  always_comb begin
    w_pos = '0;
    for (int k = 0; k < N; k++)
      w_pos[659 - 20*k -: 20] = {r_x[k], r_y[k]};
  end

  assign bus.position  = w_pos;
  assign bus.length    = r_len;
  assign bus.move_tick = r_mt;
endmodule
